// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_loader_pkg;

  // Width of the little-endian word-count field that opens a session
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    FINISH
  } state_t;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs a byte stream little-endian into WIDTH-bit words and flags the
// byte that completes each word; the completed word is presented
// combinationally alongside that final byte.
module byte_word_assembler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             word_complete,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-9:0]   shreg_q;

  // Newest byte lands on top, so after a full word the first byte sits in bits 7:0
  assign word          = {byte_data, shreg_q};
  assign word_complete = byte_valid && (cnt_q == LAST);

  // Byte counter and shift register advance only on accepted bytes
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (byte_valid) begin
      shreg_q <= word[WIDTH-1:8];
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: receives a word count and program bytes, writes
// assembled words into instruction memory and holds the CPU meanwhile.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] word_idx_q;
  logic             last_word;
  logic             over_depth;

  logic             go_start, cap_lo, cap_hi, data_acc, finish, abort;
  logic             word_complete;
  logic [WIDTH-1:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign len_full   = {in_data, len_lo_q};
  assign over_depth = 32'(len_full) > 32'(DEPTH);
  assign last_word  = (word_idx_q == len_q - 1'b1);

  byte_word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (go_start),
    .byte_valid   (data_acc),
    .byte_data    (in_data),
    .word_complete(word_complete),
    .word         (word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode, handshake and datapath control strobes
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    go_start = 1'b0;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    data_acc = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          go_start = 1'b1;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap_lo  = 1'b1;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap_hi = 1'b1;
          if (len_full == '0) begin
            state_d = FINISH;
          end else if (over_depth) begin
            abort   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_acc = 1'b1;
          if (word_complete && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = FINISH;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d = FINISH;
          end else begin
            abort   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Session registers, write port and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (go_start) begin
        done       <= 1'b0;
        error      <= 1'b0;
        cpu_hold   <= 1'b1;
        word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end
      if (cap_lo) len_lo_q <= in_data;
      if (cap_hi) len_q    <= len_full;
      if (data_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ in_data;
`endif
        if (word_complete) begin
          wr_en      <= 1'b1;
          wr_data    <= word;
          wr_addr    <= WIDTH'({word_idx_q, 2'b00});
          word_idx_q <= word_idx_q + 1'b1;
        end
      end
      if (finish) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (abort) begin
        error    <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the checksum byte to sessions.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [0:7];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic        wh_q [$];

  imem_loader #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every memory write seen between clock edges
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wh_q.push_back(cpu_hold);
    end
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wh_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL handshake_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int max_gap);
    logic [7:0] cs;
    logic [31:0] w;
    logic [15:0] len;
    cs  = '0;
    len = 16'(n);
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        cs = cs ^ w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (wr_en    !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_addr  !== 32'h0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
    checks++; if (wr_data  !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold got %b exp 0", cpu_hold); end
    checks++; if (done     !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (error    !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
  endtask

  task automatic test_load8();
    clear_log();
    pulse_start();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL load8_hold_on got %b exp 1", cpu_hold); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load8_ready got %b exp 1", in_ready); end
    send_words(8, 0);
    repeat (4) @(negedge clk);
    checks++; if (wa_q.size() !== 8) begin errors++; $display("FAIL load8_count got %0d exp 8", wa_q.size()); end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL load8_addr[%0d] got %h exp %h", i, wa_q[i], 32'(i * 4)); end
      checks++; if (wd_q[i] !== prog[i]) begin errors++; $display("FAIL load8_data[%0d] got %h exp %h", i, wd_q[i], prog[i]); end
      checks++; if (wh_q[i] !== 1'b1) begin errors++; $display("FAIL load8_hold_during_write[%0d] got %b exp 1", i, wh_q[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load8_done got %b exp 1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL load8_error got %b exp 0", error); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load8_hold_off got %b exp 0", cpu_hold); end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_cleared got %b exp 0", done); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b exp 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_hold got %b exp 0", cpu_hold); end
    repeat (2) @(negedge clk);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d exp 0", wa_q.size()); end
  endtask

  task automatic test_overlen();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL over_error got %b exp 1", error); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL over_done got %b exp 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_ready got %b exp 0", in_ready); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL over_hold got %b exp 0", cpu_hold); end
    repeat (3) @(negedge clk);
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL over_writes got %0d exp 0", wa_q.size()); end
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    send_words(2, 5);
    repeat (4) @(negedge clk);
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL gaps_count got %0d exp 2", wa_q.size()); end
    for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL gaps_addr[%0d] got %h exp %h", i, wa_q[i], 32'(i * 4)); end
      checks++; if (wd_q[i] !== prog[i]) begin errors++; $display("FAIL gaps_data[%0d] got %h exp %h", i, wd_q[i], prog[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps_done got %b exp 1", done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    clear_log();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 6; j++) begin
      w = prog[j / 4];
      send_byte(w[8*(j%4) +: 8], 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({in_ready, wr_en, cpu_hold, done, error} !== 5'b0) begin
      errors++; $display("FAIL mid_flags got %b exp 00000", {in_ready, wr_en, cpu_hold, done, error});
    end
    checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++; $display("FAIL mid_bus got %h/%h exp 0/0", wr_addr, wr_data);
    end
    repeat (5) @(negedge clk);
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL mid_writes got %0d exp 1", wa_q.size()); end
    checks++; if (wa_q.size() > 0 && wd_q[0] !== prog[0]) begin errors++; $display("FAIL mid_word0 got %h exp %h", wd_q[0], prog[0]); end
    clear_log();
    pulse_start();
    send_words(2, 0);
    repeat (4) @(negedge clk);
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL mid_reload_count got %0d exp 2", wa_q.size()); end
    for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== prog[i]) begin
        errors++; $display("FAIL mid_reload[%0d] got %h:%h exp %h:%h", i, wa_q[i], wd_q[i], 32'(i * 4), prog[i]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_reload_done got %b exp 1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] csb [0:1];
    csb[0] = 8'h44;
    csb[1] = 8'h45;
    for (int t = 0; t < 2; t++) begin
      clear_log();
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h44, 0); send_byte(8'h33, 0);
      send_byte(8'h22, 0); send_byte(8'h11, 0);
      send_byte(csb[t], 0);
      repeat (3) @(negedge clk);
      checks++; if (wa_q.size() !== 1 || wd_q[0] !== 32'h11223344) begin
        errors++; $display("FAIL csum_write[%0d] count %0d exp 1 data exp 11223344", t, wa_q.size());
      end
      checks++; if (done !== (t == 0)) begin errors++; $display("FAIL csum_done[%0d] got %b exp %b", t, done, t == 0); end
      checks++; if (error !== (t == 1)) begin errors++; $display("FAIL csum_error[%0d] got %b exp %b", t, error, t == 1); end
    end
  endtask
`endif

  initial begin
    prog[0] = 32'h00002083; prog[1] = 32'h00402103;
    prog[2] = 32'h002081B3; prog[3] = 32'hFFF10113;
    prog[4] = 32'hFE011CE3; prog[5] = 32'h00302223;
    prog[6] = 32'h0000006F; prog[7] = 32'h00302423;
    @(negedge clk);
    test_reset();
    test_load8();
    test_zero_len();
    test_overlen();
    test_gaps();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, instruction memory capacity in words.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session when idle.
REQ-006 in_data  input  8  serial program byte stream.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready.
REQ-009 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 wr_addr  output  WIDTH  byte address of written word (word index * 4).
REQ-011 wr_data  output  WIDTH  assembled instruction word.
REQ-012 cpu_hold  output  1  holds CPU in reset while a session is active.
REQ-013 done  output  1  level; last session completed without error.
REQ-014 error  output  1  level; last session aborted.

Function
REQ-015 States IDLE, LEN_LO, LEN_HI, DATA, (CHECK), FINISH; in_ready=1 only in LEN_LO, LEN_HI, DATA, CHECK.
REQ-016 IDLE: start -> LEN_LO, clear done/error, set cpu_hold; start ignored in other states.
REQ-017 LEN_LO/LEN_HI capture a 16-bit little-endian word count N, one byte per transfer.
REQ-018 After LEN_HI: N=0 -> FINISH; N>DEPTH -> set error, -> IDLE; else -> DATA.
REQ-019 DATA assembles bytes little-endian (first byte = bits 7:0); 4th byte of a word -> wr_en high on the next cycle with wr_data and wr_addr = index*4; index starts at 0.
REQ-020 Byte counter 0..3 wraps; word index increments after each write; after word N-1 is written -> CHECK if compiled in, else FINISH.
REQ-021 Bubbles (in_valid=0) stall the FSM indefinitely with no state or counter change.
REQ-022 FINISH: one cycle; set done, clear cpu_hold, -> IDLE.
REQ-023 error -> cpu_hold cleared in same cycle error is set; no write of a partial word ever issued.
REQ-024 wr_en never asserted outside DATA-driven writes; at most one write per 4 accepted data bytes.

Reset
REQ-025 reset at any cycle, including mid-session: state IDLE, counters 0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, cpu_hold=0, done=0, error=0.
REQ-026 Words already written before a mid-session reset remain in memory; loader issues no further writes.

Configuration
REQ-027 Macro IMEM_LOADER_CHECKSUM_EN defined: after the data bytes, CHECK state accepts one byte compared to the XOR of all data bytes; match -> FINISH, mismatch -> set error, -> IDLE.
REQ-028 Macro undefined: CHECK state and checksum register absent; DATA goes directly to FINISH.

Structure
REQ-029 Shared package imem_loader_pkg holds the state enum type and the 16-bit length width constant.
REQ-030 One sub-module, byte_word_assembler (byte counter, shift register, word-complete pulse), is natural; FSM stays in imem_loader.

Verification
REQ-031 Load N=8 of the loop program (words 0x00002083 .. 0x00302423) -> 8 writes, addresses 0x00..0x1C, data exact, done=1, cpu_hold falls after last write.
REQ-032 Length bytes 0x00,0x00 -> no writes, done=1 two cycles after LEN_HI transfer.
REQ-033 Length 1025 (0x01,0x04) -> error=1, done=0, no writes, in_ready=0.
REQ-034 N=2 with random in_valid gaps of 0-5 cycles -> writes identical to gap-free run.
REQ-035 reset asserted after 6 data bytes of N=4 -> exactly 1 write issued, all outputs at reset values next cycle, new start then loads correctly.
REQ-036 With IMEM_LOADER_CHECKSUM_EN, N=1 word 0x11223344, checksum byte 0x44 -> done=1; byte 0x45 -> error=1, word still written.
